// File: rtl/mmio_io_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl_pkg
// Purpose  : Shared constants for the MMIO I/O controller. Holds the base
//            page, the register offsets, the display MODE encodings, the
//            blink FSM state encoding, and a helper that gives the offset of
//            a raw HEX digit register.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_io_ctrl_pkg;

    // A hit requires addr[XLEN-1:12] to equal this page number.
    localparam logic [19:0] c_base_page      = 20'h40000;

    // Register offsets within the 4 KiB page.
    localparam logic [11:0] c_off_led        = 12'h000;
    localparam logic [11:0] c_off_sw         = 12'h100;
    localparam logic [11:0] c_off_key        = 12'h200;
    localparam logic [11:0] c_off_key_edge   = 12'h204;
    localparam logic [11:0] c_off_hex0       = 12'h300;
    localparam logic [11:0] c_off_hexvalue   = 12'h380;
    localparam logic [11:0] c_off_mode       = 12'h384;
    localparam logic [11:0] c_off_blink_div  = 12'h388;

    // Display MODE encodings.
    localparam logic [1:0]  c_mode_raw       = 2'd0;
    localparam logic [1:0]  c_mode_decoded   = 2'd1;
    localparam logic [1:0]  c_mode_blink     = 2'd2;
    localparam logic [1:0]  c_mode_reserved  = 2'd3;

    // Blink FSM state encoding.
    localparam logic [0:0]  c_blink_on       = 1'b0;
    localparam logic [0:0]  c_blink_off      = 1'b1;

    // Raw segment register of digit idx lives at 0x300 + 4*idx.
    function automatic logic [11:0] hex_offset(input int idx);
        return c_off_hex0 + 12'(4 * idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl_if
// Purpose  : Simple MMIO bus between a bus master and the I/O controller.
//            addr/wdata/wr_en/rd_en flow master->slave; rdata/rd_valid flow
//            slave->master, rd_valid pulsing one cycle after rd_en.
// Ports    : addr, wdata (XLEN), wr_en, rd_en, rdata (XLEN), rd_valid
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_io_ctrl_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            wr_en;
    logic            rd_en;
    logic [XLEN-1:0] rdata;
    logic            rd_valid;

    modport master (
        output addr, wdata, wr_en, rd_en,
        input  rdata, rd_valid
    );

    modport slave (
        input  addr, wdata, wr_en, rd_en,
        output rdata, rd_valid
    );

endinterface
`default_nettype wire

// File: rtl/hex_seg_dec.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_dec
// Purpose  : 4-bit value to seven-segment glyph (0-9, A, b, C, d, E, F).
//            Output is active-low, bit order {g,f,e,d,c,b,a}.
// Ports    : i_value [3:0] in, o_seg [6:0] out
// Revision : 1.0 - initial release
// ============================================================================
module hex_seg_dec (
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_value)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl
// Purpose  : Memory-mapped I/O controller for LEDs, switches, push-buttons
//            and a seven-segment display with raw, decoded and blink modes.
// Ports    : clock, reset (async, active-high)
//            bus   - mmio_io_ctrl_if slave (addr/wdata/wr_en/rd_en/rdata/rd_valid)
//            sw    - switch inputs (async)
//            key   - push-buttons (async, active-low)
//            led   - registered LED drive
//            hex   - segment drive, active-low, digit i on [7i+6:7i]
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_HEX   = 6,
    parameter int LED_WIDTH = 10,
    parameter int SW_WIDTH  = 10,
    parameter int KEY_WIDTH = 4,
    parameter int DIV_WIDTH = 26
) (
    input  logic                   clock,
    input  logic                   reset,
    mmio_io_ctrl_if.slave          bus,
    input  logic [SW_WIDTH-1:0]    sw,
    input  logic [KEY_WIDTH-1:0]   key,
    output logic [LED_WIDTH-1:0]   led,
    output logic [7*NUM_HEX-1:0]   hex
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        w_hit;
    logic [11:0] w_off;
    logic        w_wr;
    logic        w_wr_mode;
    logic        w_wr_div;

    assign w_hit     = (bus.addr[XLEN-1:12] == (XLEN-12)'(c_base_page));
    assign w_off     = bus.addr[11:0];
    assign w_wr      = bus.wr_en & w_hit;
    assign w_wr_mode = w_wr & (w_off == c_off_mode);
    assign w_wr_div  = w_wr & (w_off == c_off_blink_div);

    // Not every wdata bit lands in a register.
    logic w_unused;
    assign w_unused = ^bus.wdata;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [LED_WIDTH-1:0]          r_led;
    logic [NUM_HEX-1:0][6:0]       r_hex_raw;
    logic [4*NUM_HEX-1:0]          r_hexval;
    logic [1:0]                    r_mode;
    logic [DIV_WIDTH-1:0]          r_div;
    logic [KEY_WIDTH-1:0]          r_key_edge;
    logic [SW_WIDTH-1:0]           r_sw_s1;
    logic [SW_WIDTH-1:0]           r_sw_s2;
    logic [KEY_WIDTH-1:0]          r_key_s1;
    logic [KEY_WIDTH-1:0]          r_key_s2;
    logic [KEY_WIDTH-1:0]          r_key_s3;
    logic [XLEN-1:0]               r_rdata;
    logic                          r_rd_valid;

    // Keys are active-low: a press is synchronized key falling 1->0, i.e.
    // the inverted level rising. r_key_s3 is one stage older than r_key_s2.
    // All stages reset to 0, so an idle (high) key never looks like a press.
    logic [KEY_WIDTH-1:0] w_key_level;
    logic [KEY_WIDTH-1:0] w_key_press;
    logic [KEY_WIDTH-1:0] w_key_clr;

    assign w_key_level = ~r_key_s2;
    assign w_key_press = r_key_s3 & ~r_key_s2;
    assign w_key_clr   = (w_wr && (w_off == c_off_key_edge)) ?
                         bus.wdata[KEY_WIDTH-1:0] : '0;

    // Read mux sees pre-write register values, so a same-cycle read and
    // write of one register returns the old contents.
    logic [XLEN-1:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        if (w_hit) begin
            case (w_off)
                c_off_led:       w_rd_mux = XLEN'(r_led);
                c_off_sw:        w_rd_mux = XLEN'(r_sw_s2);
                c_off_key:       w_rd_mux = XLEN'(w_key_level);
                c_off_key_edge:  w_rd_mux = XLEN'(r_key_edge);
                c_off_hexvalue:  w_rd_mux = XLEN'(r_hexval);
                c_off_mode:      w_rd_mux = XLEN'(r_mode);
                c_off_blink_div: w_rd_mux = XLEN'(r_div);
                default:         w_rd_mux = '0;
            endcase
            for (int i = 0; i < NUM_HEX; i++) begin
                if (w_off == hex_offset(i)) begin
                    w_rd_mux = XLEN'(r_hex_raw[i]);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led      <= '0;
            r_hex_raw  <= '0;
            r_hexval   <= '0;
            r_mode     <= '0;
            r_div      <= '0;
            r_key_edge <= '0;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_key_s1   <= '0;
            r_key_s2   <= '0;
            r_key_s3   <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_sw_s1    <= sw;
            r_sw_s2    <= r_sw_s1;
            r_key_s1   <= key;
            r_key_s2   <= r_key_s1;
            r_key_s3   <= r_key_s2;

            // Set wins over a simultaneous write-1-to-clear.
            r_key_edge <= (r_key_edge & ~w_key_clr) | w_key_press;

            if (w_wr) begin
                if (w_off == c_off_led)       r_led    <= bus.wdata[LED_WIDTH-1:0];
                if (w_off == c_off_hexvalue)  r_hexval <= bus.wdata[4*NUM_HEX-1:0];
                if (w_off == c_off_mode)      r_mode   <= bus.wdata[1:0];
                if (w_off == c_off_blink_div) r_div    <= bus.wdata[DIV_WIDTH-1:0];
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (w_off == hex_offset(i)) begin
                        r_hex_raw[i] <= bus.wdata[6:0];
                    end
                end
            end

            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign led          = r_led;

    // ------------------------------------------------------------------
    // Blink FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    logic [0:0]           r_blink_state;
    logic [0:0]           w_blink_state_nxt;
    logic [DIV_WIDTH-1:0] r_blink_cnt;
    logic [DIV_WIDTH-1:0] w_blink_cnt_nxt;
    logic                 w_blink_on;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blink_state <= c_blink_on;
            r_blink_cnt   <= '0;
        end else begin
            r_blink_state <= w_blink_state_nxt;
            r_blink_cnt   <= w_blink_cnt_nxt;
        end
    end

    // A MODE/BLINK_DIV write restarts the period; this also keeps the
    // counter from ever sitting above a newly lowered divider.
    always_comb begin
        w_blink_state_nxt = r_blink_state;
        w_blink_cnt_nxt   = r_blink_cnt;
        if (w_wr_mode || w_wr_div) begin
            w_blink_state_nxt = c_blink_on;
            w_blink_cnt_nxt   = '0;
        end else if (r_mode != c_mode_blink) begin
            w_blink_state_nxt = c_blink_on;
            w_blink_cnt_nxt   = '0;
        end else if (r_blink_cnt == r_div) begin
            w_blink_cnt_nxt   = '0;
            w_blink_state_nxt = (r_blink_state == c_blink_on) ? c_blink_off : c_blink_on;
        end else begin
            w_blink_cnt_nxt   = r_blink_cnt + DIV_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Display drive
    // ------------------------------------------------------------------
    logic [6:0] w_dec [NUM_HEX];

    for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_digit
        hex_seg_dec u_dec (
            .i_value (r_hexval[4*gi +: 4]),
            .o_seg   (w_dec[gi])
        );
    end

    always_comb begin
        w_blink_on = (r_blink_state == c_blink_on);
        hex        = '1;
        for (int i = 0; i < NUM_HEX; i++) begin
            case (r_mode)
                c_mode_decoded: hex[7*i +: 7] = w_dec[i];
                c_mode_blink:   hex[7*i +: 7] = w_blink_on ? w_dec[i] : 7'h7F;
                default:        hex[7*i +: 7] = ~r_hex_raw[i];
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_io_ctrl
// Purpose  : Self-checking bench for mmio_io_ctrl. A register-level model
//            tracks what the controller must show; a negedge process compares
//            led/hex/rd_valid/rdata against it every cycle, and directed
//            sequences pin key values with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_io_ctrl;

    localparam logic [31:0] A_LED   = 32'h4000_0000;
    localparam logic [31:0] A_SW    = 32'h4000_0100;
    localparam logic [31:0] A_KEY   = 32'h4000_0200;
    localparam logic [31:0] A_KEDGE = 32'h4000_0204;
    localparam logic [31:0] A_HEX0  = 32'h4000_0300;
    localparam logic [31:0] A_HEXV  = 32'h4000_0380;
    localparam logic [31:0] A_MODE  = 32'h4000_0384;
    localparam logic [31:0] A_DIV   = 32'h4000_0388;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw    = 10'h155;
    logic [3:0]  key   = 4'hF;
    logic [9:0]  led;
    logic [41:0] hex;

    mmio_io_ctrl_if #(.XLEN(32)) bus ();

    mmio_io_ctrl #(
        .XLEN(32), .NUM_HEX(6), .LED_WIDTH(10),
        .SW_WIDTH(10), .KEY_WIDTH(4), .DIV_WIDTH(26)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .sw    (sw),
        .key   (key),
        .led   (led),
        .hex   (hex)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [9:0]  m_led    = '0;
    logic [6:0]  m_hexraw [6];
    logic [23:0] m_hexval = '0;
    logic [1:0]  m_mode   = '0;
    logic [25:0] m_div    = '0;
    logic [3:0]  m_edge   = '0;
    int          m_since  = 0;   // cycles since last MODE/BLINK_DIV write
    logic        m_rv     = 1'b0;
    logic [31:0] m_rd     = '0;
    // input samples taken at the last three clock edges (p1 newest)
    logic [9:0]  sw_p1 = '0, sw_p2 = '0;
    logic [3:0]  key_p1 = '0, key_p2 = '0, key_p3 = '0;
    logic [3:0]  set_b, clr_b;
    logic        cfg_wr;
    logic [11:0] moff;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [11:0] o;
        logic [3:0]  kl;
        if (a[31:12] != 20'h40000) return 32'h0;
        o  = a[11:0];
        kl = ~key_p2;
        case (o)
            12'h000: return {22'h0, m_led};
            12'h100: return {22'h0, sw_p2};
            12'h200: return {28'h0, kl};
            12'h204: return {28'h0, m_edge};
            12'h380: return {8'h0, m_hexval};
            12'h384: return {30'h0, m_mode};
            12'h388: return {6'h0, m_div};
            default: begin
                if (o >= 12'h300 && o < 12'h318 && o[1:0] == 2'b00)
                    return {25'h0, m_hexraw[(o - 12'h300) >> 2]};
                return 32'h0;
            end
        endcase
    endfunction

    function automatic logic [41:0] model_hex();
        logic [41:0] h;
        logic        on;
        on = ((m_since / (int'(m_div) + 1)) % 2) == 0;
        for (int i = 0; i < 6; i++) begin
            case (m_mode)
                2'd1:    h[7*i +: 7] = glyph(m_hexval[4*i +: 4]);
                2'd2:    h[7*i +: 7] = on ? glyph(m_hexval[4*i +: 4]) : 7'h7F;
                default: h[7*i +: 7] = ~m_hexraw[i];
            endcase
        end
        return h;
    endfunction

    initial begin
        for (int i = 0; i < 6; i++) m_hexraw[i] = '0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_led = '0; m_hexval = '0; m_mode = '0; m_div = '0; m_edge = '0;
                m_since = 0; m_rv = 1'b0; m_rd = '0;
                for (int i = 0; i < 6; i++) m_hexraw[i] = '0;
                sw_p1 = '0; sw_p2 = '0; key_p1 = '0; key_p2 = '0; key_p3 = '0;
            end else begin
                m_rv = bus.rd_en;
                if (bus.rd_en) m_rd = model_read(bus.addr);
                set_b  = key_p3 & ~key_p2;   // synchronized key went high->low
                clr_b  = '0;
                cfg_wr = 1'b0;
                moff   = bus.addr[11:0];
                if (bus.wr_en && bus.addr[31:12] == 20'h40000) begin
                    case (moff)
                        12'h000: m_led    = bus.wdata[9:0];
                        12'h204: clr_b    = bus.wdata[3:0];
                        12'h380: m_hexval = bus.wdata[23:0];
                        12'h384: begin m_mode = bus.wdata[1:0];  cfg_wr = 1'b1; end
                        12'h388: begin m_div  = bus.wdata[25:0]; cfg_wr = 1'b1; end
                        default: if (moff >= 12'h300 && moff < 12'h318 && moff[1:0] == 2'b00)
                                     m_hexraw[(moff - 12'h300) >> 2] = bus.wdata[6:0];
                    endcase
                end
                m_edge  = (m_edge & ~clr_b) | set_b;
                m_since = cfg_wr ? 0 : m_since + 1;
                key_p3 = key_p2; key_p2 = key_p1; key_p1 = key;
                sw_p2  = sw_p1;  sw_p1  = sw;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("sb_rst_led", led, 0);
                chk("sb_rst_hex", hex, {42{1'b1}});
                chk("sb_rst_rv",  bus.rd_valid, 0);
            end else begin
                chk("sb_led", led, m_led);
                chk("sb_hex", hex, model_hex());
                chk("sb_rv",  bus.rd_valid, m_rv);
                if (m_rv) chk("sb_rdata", bus.rdata, m_rd);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        bus.addr = a; bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        v = bus.rd_valid;
        d = bus.rdata;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        rd(a, d, v);
        chk({name, "_valid"}, v, 1);
        chk(name, d, exp);
    endtask

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_led", led, 0);
        chk("rst_hex", hex, {42{1'b1}});
        chk("rst_rv",  bus.rd_valid, 0);
        reset = 1'b0;
        rd_chk("rst_mode", A_MODE, 32'h0);
        rd_chk("rst_kedge", A_KEDGE, 32'h0);

        // LED write then read
        wr(A_LED, 32'h2A5);
        rd_chk("led_rd", A_LED, 32'h2A5);
        chk("led_out", led, 10'h2A5);
        rd_chk("sw_rd", A_SW, 32'h155);

        // Raw segments
        wr(A_HEX0, 32'h5A);
        chk("raw_d0", hex[6:0], 7'h25);
        wr(A_HEX0 + 32'h14, 32'h7F);
        chk("raw_d5", hex[41:35], 7'h00);
        rd_chk("hex5_rd", A_HEX0 + 32'h14, 32'h7F);
        wr(A_HEX0 + 32'h18, 32'h11);
        rd_chk("hex6_unmapped", A_HEX0 + 32'h18, 32'h0);

        // Decoded
        wr(A_HEXV, 32'h0012_AB3F);
        wr(A_MODE, 32'h1);
        chk("dec_d0", hex[6:0],   7'h0E);
        chk("dec_d1", hex[13:7],  7'h30);
        chk("dec_d5", hex[41:35], 7'h79);
        rd_chk("hexv_rd", A_HEXV, 32'h0012_AB3F);

        // Blink, period of 4 on / 4 off
        wr(A_DIV, 32'h3);
        wr(A_MODE, 32'h2);
        for (int c = 0; c < 6; c++) begin
            chk("blink_a", hex[6:0], ((c / 4) % 2 == 0) ? 7'h0E : 7'h7F);
            step();
        end
        // Now in the off phase; a divider write restarts in ON
        wr(A_DIV, 32'h3);
        for (int c = 0; c < 8; c++) begin
            chk("blink_b", hex[6:0], ((c / 4) % 2 == 0) ? 7'h0E : 7'h7F);
            step();
        end
        wr(A_DIV, 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("blink_div0", hex[6:0], (c % 2 == 0) ? 7'h0E : 7'h7F);
            step();
        end
        wr(A_MODE, 32'h3);
        chk("mode3_raw", hex[6:0], 7'h25);

        // Key press edge latency
        key[1] = 1'b0;
        step();
        step();
        rd_chk("kedge_early", A_KEDGE, 32'h0);
        rd_chk("kedge_set", A_KEDGE, 32'h2);
        rd_chk("key_level", A_KEY, 32'h2);
        wr(A_KEDGE, 32'h2);
        rd_chk("kedge_clr", A_KEDGE, 32'h0);
        key[1] = 1'b1;
        repeat (4) step();
        // New press timed so its set lands on the same edge as a clear
        key[1] = 1'b0;
        step();
        step();
        wr(A_KEDGE, 32'h2);
        rd_chk("kedge_setwins", A_KEDGE, 32'h2);
        wr(A_KEDGE, 32'h2);
        rd_chk("kedge_clr2", A_KEDGE, 32'h0);
        key[1] = 1'b1;

        // RO and miss writes are ignored
        sw = 10'h0AA;
        wr(A_SW, 32'hFFFF_FFFF);
        wr(32'h1000_0000, 32'h3FF);
        rd_chk("miss_led", A_LED, 32'h2A5);
        rd_chk("unmapped", 32'h4000_0390, 32'h0);
        rd_chk("miss_rd", 32'h1000_0000, 32'h0);
        rd_chk("sw_rd2", A_SW, 32'h0AA);

        // Same-cycle read and write returns the old value
        bus.addr = A_LED; bus.wdata = 32'h0F0; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("rdwr_old", bus.rdata, 32'h2A5);
        chk("rdwr_led", led, 10'h0F0);

        // Async reset while a read result is outstanding
        bus.addr = A_LED; bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_led", led, 0);
        chk("arst_hex", hex, {42{1'b1}});
        chk("arst_rv",  bus.rd_valid, 0);
        // Read requested between edges while reset is held is dropped
        bus.rd_en = 1'b1;
        @(posedge clock);
        #3;
        bus.rd_en = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("arst_rv_after", bus.rd_valid, 0);
        end
        rd_chk("arst_led_rd", A_LED, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_io_ctrl.md
MMIO_IO_CTRL -- requirements
Module: mmio_io_ctrl

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter NUM_HEX, default 6, legal 1..8: number of seven-segment digits.
REQ-003 Parameter LED_WIDTH, default 10: LED register width.
REQ-004 Parameter SW_WIDTH, default 10: switch input width.
REQ-005 Parameter KEY_WIDTH, default 4: push-button input width.
REQ-006 Parameter DIV_WIDTH, default 26: blink divider width.
REQ-007 Ports shall be exactly as follows; clock and reset are listed first.
REQ-008 clock, input, 1: the single clock; all state changes on its rising edge.
REQ-009 reset, input, 1: asynchronous, active-high reset.
REQ-010 addr, input, XLEN: byte address of the access.
REQ-011 wdata, input, XLEN: write data.
REQ-012 wr_en, input, 1: write strobe, one access per cycle.
REQ-013 rd_en, input, 1: read strobe.
REQ-014 rdata, output, XLEN: read data, qualified by rd_valid.
REQ-015 rd_valid, output, 1: one-cycle pulse when rdata is valid.
REQ-016 sw, input, SW_WIDTH: asynchronous switch inputs.
REQ-017 key, input, KEY_WIDTH: asynchronous push-buttons, active-low.
REQ-018 led, output, LED_WIDTH: LED drive, registered.
REQ-019 hex, output, 7*NUM_HEX: segment drive, active-low; digit i is on bits [7i+6:7i].

Function
REQ-020 Address decode: a hit requires addr[XLEN-1:12] = 0x40000; the offset is addr[11:0].
REQ-021 Register map:
- 0x000 LED (RW)
- 0x100 SW (RO)
- 0x200 KEY level (RO)
- 0x204 KEY_EDGE (RW1C)
- 0x300+4i HEXi raw segments (RW, i<NUM_HEX)
- 0x380 HEXVALUE (RW, 4*NUM_HEX bits)
- 0x384 MODE (RW, 2 bits)
- 0x388 BLINK_DIV (RW, DIV_WIDTH bits)
REQ-022 Writes take effect on the clock edge where wr_en is high; writes to RO or unmapped addresses, or misses, shall be ignored.
REQ-023 Read latency shall be 1 cycle: rd_valid is high exactly one cycle after rd_en; rdata is zero-extended, and is 0 for unmapped addresses or misses.
REQ-024 A read and a write to the same register in the same cycle shall return the pre-write value.
REQ-025 sw and key shall pass through a 2-flop synchronizer; the KEY level read returns the synchronized, inverted key (1 = pressed).
REQ-026 A press edge (synchronized level 0->1) shall set the matching KEY_EDGE bit; bits stay set until a 1 is written to that bit.
REQ-027 If a set and a clear of the same KEY_EDGE bit occur in the same cycle, the set shall win.
REQ-028 MODE 0, RAW: digit i drives ~HEXi[6:0].
REQ-029 MODE 1, DECODED: digit i drives the hex-decoded value of HEXVALUE[4i+3:4i] (0-F glyphs, active-low).
REQ-030 MODE 2, BLINK: the display shall follow DECODED during the on-phase and show all segments off (7'h7F) during the off-phase.
REQ-031 MODE 3 is reserved and shall behave as RAW.
REQ-032 Blink FSM states are ON and OFF. A counter increments every cycle in BLINK mode; when it equals BLINK_DIV, the counter clears and the state toggles.
REQ-033 BLINK_DIV = 0 shall toggle the blink state every cycle.
REQ-034 Any write to MODE or BLINK_DIV shall clear the counter and force state ON.
REQ-035 Outside BLINK mode, the counter shall hold at 0 and the state shall be ON.
REQ-036 The counter shall never exceed BLINK_DIV; if BLINK_DIV is lowered below the current count, the write-clear of REQ-034 applies.

Reset
REQ-037 Asserting reset shall asynchronously clear the following to 0: LED, all HEXi, HEXVALUE, MODE, BLINK_DIV, KEY_EDGE, the synchronizers, rdata, rd_valid and the counter; the blink state shall be ON.
REQ-038 While reset is held, led shall be 0 and hex shall be all-ones (blank).
REQ-039 A read that is in flight when reset asserts shall be dropped, with no rd_valid after reset.

Structure
REQ-040 The shared package holds the base address, all offsets, the MODE encodings and the blink state encoding.
REQ-041 The hex-to-segment decoder shall be one sub-module, hex_seg_dec (4-bit in, 7-bit active-low out), instantiated NUM_HEX times.

Verification
REQ-042 Write LED = 0x2A5, then read 0x40000000: rd_valid is high 1 cycle later, rdata = 0x2A5, and led = 10'h2A5.
REQ-043 With MODE = 1 and HEXVALUE = 0x12AB3F, hex digit 0 = 7'h0E ('F'), digit 1 = 7'h30 ('3'), and digit 5 = 7'h79 ('1').
REQ-044 With MODE = 2 and BLINK_DIV = 3, hex alternates decoded and 7'h7F every 4 cycles; a write to BLINK_DIV mid-period restarts in ON.
REQ-045 A key[1] press is seen as KEY_EDGE = 0x2 three cycles after the raw edge. Writing 0x2 in the same cycle as a new key[1] edge leaves the bit 1; a later write of 0x2 clears it.
REQ-046 Assert reset asynchronously between clock edges during a pending read: led = 0, hex is all-ones, and rd_valid stays 0.
REQ-047 Write to 0x40000100 (SW), then a miss write to 0x10000000: neither changes any register, and a read of 0x40000390 returns 0.
